// File: rtl/clut_lookup.sv
// Palette lookup stage: maps 8-bit colour indices through a 256 x 24-bit
// colour look-up RAM and emits RGB888 pixels, one per clock, with a
// two-register pipeline (RAM output register, then output register).

package clut_lookup_pkg;
    // Plane coding delivered alongside the pixelstream.
    typedef enum logic [1:0] {
        kCLUT8  = 2'd0,
        kCLUT7  = 2'd1,
        kMosaic = 2'd2,
        kDirect = 2'd3
    } file_type_e;
endpackage

// Valid/accept pixel handshake: the source drives pixel and write, the sink
// answers with strobe; a pixel moves when write && strobe.
interface pixelstream;
    logic [7:0] pixel;
    logic       write;
    logic       strobe;

    modport sink   (input pixel, input write, output strobe);
    modport source (output pixel, output write, input strobe);
endinterface

module clut_lookup
    import clut_lookup_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    pixelstream.sink    src,
    input  file_type_e  ft,
    input  logic        plane_b,
    output logic [23:0] dst_rgb,
    output logic        dst_write,
    input  logic        dst_strobe,
    input  logic        clut_we,
    input  logic [7:0]  clut_addr,
    input  logic [23:0] clut_data
);

    // In 7-bit modes the plane selects which half of the palette is used.
    function automatic logic [7:0] eff_addr(input file_type_e f,
                                            input logic       pb,
                                            input logic [7:0] px);
        logic [7:0] a;
        case (f)
            kCLUT7, kMosaic: a = {pb, px[6:0]};
            default:         a = px;
        endcase
        return a;
    endfunction

    logic [23:0] mem [256];

    logic        vld_p1;
    logic        vld_p2;
    logic [23:0] rgb_p1;
    logic [23:0] rgb_p2;

    logic        s2_free;
    logic        s1_adv;
    logic        accept_p0;
    logic [7:0]  rd_addr_p0;

    // Handshake: s2 can take data when empty or draining this cycle; s1 can
    // take a new index when empty or moving into s2. dst_strobe reaches
    // src.strobe combinationally so a release refills without a bubble.
    always_comb begin
        s2_free    = !vld_p2 || dst_strobe;
        s1_adv     = vld_p1 && s2_free;
        src.strobe = !reset && (!vld_p1 || s2_free);
        accept_p0  = src.write && src.strobe;
        rd_addr_p0 = eff_addr(ft, plane_b, src.pixel);
    end

    // Palette write port; independent of the pixel pipeline.
    always_ff @(posedge clk) begin
        if (clut_we) begin
            mem[clut_addr] <= clut_data;
        end
    end

    // ---- p0 -> p1: RAM read. Enabled only on accept so a stalled s1 keeps
    // its colour. A same-cycle write to the same address is not visible here
    // (old data is read).
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            rgb_p1 <= mem[rd_addr_p0];
        end
    end

    // Pipeline occupancy: reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept_p0) begin
                vld_p1 <= 1'b1;
            end else if (s1_adv) begin
                vld_p1 <= 1'b0;
            end
            if (s1_adv) begin
                vld_p2 <= 1'b1;
            end else if (vld_p2 && dst_strobe) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    // ---- p1 -> p2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_p2 <= 24'h000000;
        end else if (s1_adv) begin
            rgb_p2 <= rgb_p1;
        end
    end

    assign dst_rgb   = rgb_p2;
    assign dst_write = vld_p2;

endmodule

// File: tb/tb_clut_lookup.sv
// Directed bench for clut_lookup: reset, streaming, 7-bit addressing,
// randomised backpressure, write collision and mid-stream reset.
module tb_clut_lookup;
    import clut_lookup_pkg::*;

    logic        clk;
    logic        reset;
    file_type_e  ft;
    logic        plane_b;
    logic [23:0] dst_rgb;
    logic        dst_write;
    logic        dst_strobe;
    logic        clut_we;
    logic [7:0]  clut_addr;
    logic [23:0] clut_data;

    pixelstream ps ();

    clut_lookup dut (
        .clk        (clk),
        .reset      (reset),
        .src        (ps),
        .ft         (ft),
        .plane_b    (plane_b),
        .dst_rgb    (dst_rgb),
        .dst_write  (dst_write),
        .dst_strobe (dst_strobe),
        .clut_we    (clut_we),
        .clut_addr  (clut_addr),
        .clut_data  (clut_data)
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] pal [256];

    // Addressing vectors: plane coding, plane_b, pixel, expected RAM address.
    file_type_e  ft_v   [6] = '{kCLUT7, kCLUT7, kMosaic, kMosaic, kCLUT8, kDirect};
    logic        pb_v   [6] = '{1'b1,   1'b0,   1'b1,    1'b0,    1'b1,   1'b1};
    logic [7:0]  px_v   [6] = '{8'h05,  8'h85,  8'h7F,   8'hFF,   8'h05,  8'h33};
    logic [7:0]  addr_v [6] = '{8'h85,  8'h05,  8'hFF,   8'h7F,   8'h05,  8'h33};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ps.write = 1'b1; ps.pixel = 8'h00; dst_strobe = 1'b1;
        clut_we = 1'b0; clut_addr = 8'h00; clut_data = 24'h0;
        ft = kCLUT8; plane_b = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            checks++;
            if (dst_write !== 1'b0) begin errors++; $display("FAIL reset_dst_write got %b want 0", dst_write); end
            checks++;
            if (dst_rgb !== 24'h0) begin errors++; $display("FAIL reset_dst_rgb got %h want 000000", dst_rgb); end
            checks++;
            if (ps.strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", ps.strobe); end
        end
        cyc();
        reset = 1'b0; ps.write = 1'b0;
        #1;
        checks++;
        if (ps.strobe !== 1'b1) begin errors++; $display("FAIL post_reset_strobe got %b want 1", ps.strobe); end
        checks++;
        if (dst_write !== 1'b0) begin errors++; $display("FAIL post_reset_dst_write got %b want 0", dst_write); end
    endtask

    task automatic load_palette();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            cyc();
            clut_we = 1'b1; clut_addr = b; clut_data = {b, ~b, b ^ 8'h5A};
            pal[i] = {b, ~b, b ^ 8'h5A};
        end
        cyc();
        clut_we = 1'b0;
    endtask

    task automatic test_streaming();
        ft = kCLUT8; dst_strobe = 1'b1;
        for (int c = 0; c < 258; c++) begin
            cyc();
            ps.write = (c < 256);
            ps.pixel = c[7:0];
            #1;
            if (c < 256) begin
                checks++;
                if (ps.strobe !== 1'b1) begin errors++; $display("FAIL stream_strobe cyc %0d got %b want 1", c, ps.strobe); end
            end
            checks++;
            if (dst_write !== (c >= 2)) begin errors++; $display("FAIL stream_write cyc %0d got %b want %b", c, dst_write, c >= 2); end
            if (c >= 2) begin
                checks++;
                if (dst_rgb !== pal[c-2]) begin errors++; $display("FAIL stream_rgb idx %0d got %h want %h", c - 2, dst_rgb, pal[c-2]); end
            end
        end
        cyc();
        ps.write = 1'b0;
        #1;
        checks++;
        if (dst_write !== 1'b0) begin errors++; $display("FAIL stream_tail got %b want 0", dst_write); end
    endtask

    task automatic test_clut7();
        dst_strobe = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c < 6) begin
                ps.write = 1'b1; ps.pixel = px_v[c]; ft = ft_v[c]; plane_b = pb_v[c];
            end else begin
                // Changes after accept must not affect pixels in flight.
                ps.write = 1'b0; ps.pixel = 8'h00; ft = kCLUT7; plane_b = ~plane_b;
            end
            #1;
            if (c >= 2) begin
                checks++;
                if (dst_write !== 1'b1) begin errors++; $display("FAIL mode_write vec %0d got %b want 1", c - 2, dst_write); end
                checks++;
                if (dst_rgb !== pal[addr_v[c-2]]) begin errors++; $display("FAIL mode_rgb vec %0d got %h want %h", c - 2, dst_rgb, pal[addr_v[c-2]]); end
            end
        end
        cyc();
        ft = kCLUT8; plane_b = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [23:0] q [$];
        logic        prev_stall;
        logic [23:0] prev_rgb;
        logic        exp_strobe;
        logic [23:0] exp_rgb;
        int acc;
        int n;
        acc = 0; n = 0; prev_stall = 1'b0; prev_rgb = 24'h0;
        ft = kCLUT8;
        while ((acc < 1000 || q.size() != 0) && n < 6000) begin
            cyc();
            if (acc < 1000) begin
                dst_strobe = 1'($urandom_range(0, 1));
                ps.write   = ($urandom_range(0, 3) != 0);
                ps.pixel   = 8'($urandom_range(0, 255));
            end else begin
                dst_strobe = 1'b1;
                ps.write   = 1'b0;
            end
            #1;
            exp_strobe = !(q.size() == 2 && !dst_strobe);
            checks++;
            if (ps.strobe !== exp_strobe) begin errors++; $display("FAIL bp_strobe cyc %0d got %b want %b", n, ps.strobe, exp_strobe); end
            if (prev_stall) begin
                checks++;
                if (dst_write !== 1'b1 || dst_rgb !== prev_rgb) begin
                    errors++; $display("FAIL bp_hold cyc %0d got %b/%h want 1/%h", n, dst_write, dst_rgb, prev_rgb);
                end
            end
            if (dst_write === 1'b1 && dst_strobe) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra cyc %0d got %h want no output", n, dst_rgb);
                end else begin
                    exp_rgb = q.pop_front();
                    if (dst_rgb !== exp_rgb) begin errors++; $display("FAIL bp_rgb cyc %0d got %h want %h", n, dst_rgb, exp_rgb); end
                end
            end
            if (ps.write && ps.strobe === 1'b1) begin
                q.push_back(pal[ps.pixel]);
                acc++;
            end
            prev_stall = (dst_write === 1'b1) && !dst_strobe;
            prev_rgb   = dst_rgb;
            n++;
        end
        checks++;
        if (acc < 1000 || q.size() != 0) begin
            errors++; $display("FAIL bp_timeout accepted %0d pending %0d want 1000/0", acc, q.size());
        end
        cyc();
        #1;
        checks++;
        if (dst_write !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", dst_write); end
    endtask

    task automatic test_collision();
        dst_strobe = 1'b1; ft = kCLUT8;
        cyc();
        ps.write = 1'b0; clut_we = 1'b1; clut_addr = 8'h10; clut_data = 24'h111111;
        cyc();
        ps.write = 1'b1; ps.pixel = 8'h10; clut_we = 1'b1; clut_data = 24'h222222;
        cyc();
        ps.write = 1'b1; clut_we = 1'b0;
        cyc();
        ps.write = 1'b0;
        #1;
        checks++;
        if (dst_write !== 1'b1 || dst_rgb !== 24'h111111) begin
            errors++; $display("FAIL collide_old got %b/%h want 1/111111", dst_write, dst_rgb);
        end
        cyc();
        #1;
        checks++;
        if (dst_write !== 1'b1 || dst_rgb !== 24'h222222) begin
            errors++; $display("FAIL collide_new got %b/%h want 1/222222", dst_write, dst_rgb);
        end
        pal[8'h10] = 24'h222222;
        cyc();
        #1;
        checks++;
        if (dst_write !== 1'b0) begin errors++; $display("FAIL collide_tail got %b want 0", dst_write); end
    endtask

    task automatic test_reset_mid();
        dst_strobe = 1'b0; ft = kCLUT8;
        cyc();
        ps.write = 1'b1; ps.pixel = 8'h03;
        #1;
        checks++;
        if (ps.strobe !== 1'b1) begin errors++; $display("FAIL mid_strobe0 got %b want 1", ps.strobe); end
        cyc();
        ps.pixel = 8'h04;
        #1;
        checks++;
        if (ps.strobe !== 1'b1) begin errors++; $display("FAIL mid_strobe1 got %b want 1", ps.strobe); end
        cyc();
        ps.pixel = 8'h05;
        #1;
        checks++;
        if (ps.strobe !== 1'b0) begin errors++; $display("FAIL mid_full got %b want 0", ps.strobe); end
        checks++;
        if (dst_write !== 1'b1 || dst_rgb !== pal[3]) begin
            errors++; $display("FAIL mid_held got %b/%h want 1/%h", dst_write, dst_rgb, pal[3]);
        end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; ps.write = 1'b0; dst_strobe = 1'b1;
        #1;
        checks++;
        if (dst_write !== 1'b0 || dst_rgb !== 24'h0) begin
            errors++; $display("FAIL mid_reset got %b/%h want 0/000000", dst_write, dst_rgb);
        end
        checks++;
        if (ps.strobe !== 1'b1) begin errors++; $display("FAIL mid_strobe_after got %b want 1", ps.strobe); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            checks++;
            if (dst_write !== 1'b0) begin errors++; $display("FAIL mid_ghost cyc %0d got %b want 0", c, dst_write); end
        end
        // Palette survives reset.
        for (int c = 0; c < 5; c++) begin
            cyc();
            ps.write = (c < 3);
            ps.pixel = (c == 0) ? 8'h03 : (c == 1) ? 8'h10 : 8'hC4;
            #1;
            if (c >= 2) begin
                logic [7:0] a;
                a = (c == 2) ? 8'h03 : (c == 3) ? 8'h10 : 8'hC4;
                checks++;
                if (dst_write !== 1'b1 || dst_rgb !== pal[a]) begin
                    errors++; $display("FAIL mid_palette addr %h got %b/%h want 1/%h", a, dst_write, dst_rgb, pal[a]);
                end
            end
        end
    endtask

    initial begin
        ps.write = 1'b0;
        ps.pixel = 8'h00;
        test_reset();
        load_palette();
        test_streaming();
        test_clut7();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
